// File: rtl/bti_arb.sv
`default_nettype none
// ============================================================================
// Module   : bti_arb
// Brief    : Merges the rv32i instruction-side (m0) and data-side (m1) BTI
//            master ports onto one BTI slave port. The grant is locked until
//            the slave accepts it. An in-order owner FIFO steers each slave
//            response back to the master that issued the request.
// Options  : BTI_ARB_RR_EN - round-robin conflict resolution. When it is not
//            defined, m1 (data side) always wins a conflict.
// Revision : 1.0 - initial release
// ============================================================================
module bti_arb #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int OST_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  // master 0 (instruction side)
  input  logic                       m0_req_vld,
  output logic                       m0_req_rdy,
  input  logic [AW-1:0]              m0_req_addr,
  input  logic                       m0_req_wr,
  input  logic [DW-1:0]              m0_req_wdata,
  input  logic [DW/8-1:0]            m0_req_wstrb,
  output logic                       m0_rsp_vld,
  input  logic                       m0_rsp_rdy,
  output logic [DW-1:0]              m0_rsp_rdata,
  output logic                       m0_rsp_err,
  // master 1 (data side)
  input  logic                       m1_req_vld,
  output logic                       m1_req_rdy,
  input  logic [AW-1:0]              m1_req_addr,
  input  logic                       m1_req_wr,
  input  logic [DW-1:0]              m1_req_wdata,
  input  logic [DW/8-1:0]            m1_req_wstrb,
  output logic                       m1_rsp_vld,
  input  logic                       m1_rsp_rdy,
  output logic [DW-1:0]              m1_rsp_rdata,
  output logic                       m1_rsp_err,
  // slave port
  output logic                       s_req_vld,
  input  logic                       s_req_rdy,
  output logic [AW-1:0]              s_req_addr,
  output logic                       s_req_wr,
  output logic [DW-1:0]              s_req_wdata,
  output logic [DW/8-1:0]            s_req_wstrb,
  input  logic                       s_rsp_vld,
  output logic                       s_rsp_rdy,
  input  logic [DW-1:0]              s_rsp_rdata,
  input  logic                       s_rsp_err,
  // status
  output logic [$clog2(OST_DEPTH):0] ost_cnt,
  output logic                       err_stray
);

  localparam int                 c_ptr_w = $clog2(OST_DEPTH);
  localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w+1)'(OST_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w+1)'(1);

  logic               r_lock;
  logic               r_lock_own;
  logic               r_err_stray;
  logic [c_ptr_w:0]   r_cnt;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic               r_owner_q [OST_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_prio;
  logic w_gnt;
  logic w_gnt_vld;
  logic w_push;
  logic w_pop;
  logic w_stray;
  logic w_head;

  assign w_full  = (r_cnt == c_full);
  assign w_empty = (r_cnt == '0);

`ifdef BTI_ARB_RR_EN
  logic r_prio;

  // Round-robin pointer: after every accepted request, favour the other master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b1;
    end else if (w_push) begin
      r_prio <= ~w_gnt;
    end
  end

  assign w_prio = r_prio;
`else
  assign w_prio = 1'b1;
`endif

  // Grant select: a locked owner wins outright, otherwise resolve the request pair.
  always_comb begin
    w_gnt = 1'b0;
    if (r_lock) begin
      w_gnt = r_lock_own;
    end else if (m0_req_vld && m1_req_vld) begin
      w_gnt = w_prio;
    end else if (m1_req_vld) begin
      w_gnt = 1'b1;
    end
  end

  // Request path: payload follows the grant; a full owner FIFO blocks everything.
  assign w_gnt_vld   = w_gnt ? m1_req_vld   : m0_req_vld;
  assign s_req_vld   = w_gnt_vld && !w_full;
  assign s_req_addr  = w_gnt ? m1_req_addr  : m0_req_addr;
  assign s_req_wr    = w_gnt ? m1_req_wr    : m0_req_wr;
  assign s_req_wdata = w_gnt ? m1_req_wdata : m0_req_wdata;
  assign s_req_wstrb = w_gnt ? m1_req_wstrb : m0_req_wstrb;
  assign m0_req_rdy  = !w_gnt && s_req_rdy && !w_full;
  assign m1_req_rdy  =  w_gnt && s_req_rdy && !w_full;

  // Response path: the FIFO head names the owner; an empty FIFO swallows strays.
  assign w_head       = r_owner_q[r_rptr];
  assign m0_rsp_vld   = s_rsp_vld && !w_empty && !w_head;
  assign m1_rsp_vld   = s_rsp_vld && !w_empty &&  w_head;
  assign m0_rsp_rdata = s_rsp_rdata;
  assign m1_rsp_rdata = s_rsp_rdata;
  assign m0_rsp_err   = s_rsp_err;
  assign m1_rsp_err   = s_rsp_err;
  assign s_rsp_rdy    = w_empty ? s_rsp_vld : (w_head ? m1_rsp_rdy : m0_rsp_rdy);

  assign w_push  = s_req_vld && s_req_rdy;
  assign w_pop   = s_rsp_vld && s_rsp_rdy && !w_empty;
  assign w_stray = s_rsp_vld && w_empty;

  // Control state: grant lock, FIFO pointers/occupancy and the stray pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock      <= 1'b0;
      r_lock_own  <= 1'b0;
      r_err_stray <= 1'b0;
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      r_err_stray <= w_stray;
      if (w_push) begin
        r_lock <= 1'b0;
      end else if (s_req_vld) begin
        r_lock     <= 1'b1;
        r_lock_own <= w_gnt;
      end
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_cnt_one;
        2'b01:   r_cnt <= r_cnt - c_cnt_one;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Owner storage: record which master issued each accepted request.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_owner_q[r_wptr] <= w_gnt;
    end
  end

  assign ost_cnt   = r_cnt;
  assign err_stray = r_err_stray;

endmodule
`default_nettype wire

// File: tb/tb_bti_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_bti_arb
// Brief    : Self-checking bench for bti_arb. Expected slave-side requests
//            and expected response owners are queued by the bench and
//            compared as the DUT hands them over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bti_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OST_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic m0_req_vld, m0_req_rdy, m0_req_wr, m0_rsp_vld, m0_rsp_rdy, m0_rsp_err;
  logic m1_req_vld, m1_req_rdy, m1_req_wr, m1_rsp_vld, m1_rsp_rdy, m1_rsp_err;
  logic [AW-1:0] m0_req_addr, m1_req_addr, s_req_addr;
  logic [DW-1:0] m0_req_wdata, m1_req_wdata, m0_rsp_rdata, m1_rsp_rdata;
  logic [DW/8-1:0] m0_req_wstrb, m1_req_wstrb, s_req_wstrb;
  logic s_req_vld, s_req_rdy, s_req_wr, s_rsp_vld, s_rsp_rdy, s_rsp_err;
  logic [DW-1:0] s_req_wdata, s_rsp_rdata;
  logic [$clog2(OST_DEPTH):0] ost_cnt;
  logic err_stray;

  typedef struct packed {
    logic          own;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
  } req_t;

  req_t exp_req[$];
  logic rsp_q[$];
  logic stray_pend;
  int   n_vec;
  int   n_err;

  bti_arb #(.AW(AW), .DW(DW), .OST_DEPTH(OST_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
    .m0_req_wr(m0_req_wr), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_rdata(m0_rsp_rdata),
    .m0_rsp_err(m0_rsp_err),
    .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
    .m1_req_wr(m1_req_wr), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_rdata(m1_rsp_rdata),
    .m1_rsp_err(m1_rsp_err),
    .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_addr(s_req_addr),
    .s_req_wr(s_req_wr), .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
    .s_rsp_vld(s_rsp_vld), .s_rsp_rdy(s_rsp_rdy), .s_rsp_rdata(s_rsp_rdata),
    .s_rsp_err(s_rsp_err),
    .ost_cnt(ost_cnt), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic own, input logic [AW-1:0] addr, input logic wr,
                          input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
    req_t e;
    e.own = own; e.addr = addr; e.wr = wr; e.wdata = wdata; e.wstrb = wstrb;
    exp_req.push_back(e);
  endtask

  task automatic set_m0(input logic vld, input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
    m0_req_vld = vld; m0_req_addr = addr; m0_req_wr = wr;
    m0_req_wdata = wdata; m0_req_wstrb = wstrb;
  endtask

  task automatic set_m1(input logic vld, input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
    m1_req_vld = vld; m1_req_addr = addr; m1_req_wr = wr;
    m1_req_wdata = wdata; m1_req_wstrb = wstrb;
  endtask

  task automatic set_rsp(input logic vld, input logic [DW-1:0] rdata, input logic err);
    s_rsp_vld = vld; s_rsp_rdata = rdata; s_rsp_err = err;
  endtask

  // Called right after a negedge with inputs driven: check, then run one clock.
  task automatic step();
    req_t e;
    logic own;
    logic rdy;
    #2;
    chk("ost_cnt", 64'(ost_cnt), 64'(rsp_q.size()));
    chk("err_stray", 64'(err_stray), 64'(stray_pend));
    stray_pend = 1'b0;
    if (s_rsp_vld) begin
      if (rsp_q.size() == 0) begin
        chk("stray_m0_vld", 64'(m0_rsp_vld), 64'd0);
        chk("stray_m1_vld", 64'(m1_rsp_vld), 64'd0);
        chk("stray_rdy", 64'(s_rsp_rdy), 64'd1);
        stray_pend = 1'b1;
      end else begin
        own = rsp_q[0];
        rdy = own ? m1_rsp_rdy : m0_rsp_rdy;
        chk("rsp_route_m0", 64'(m0_rsp_vld), 64'(!own));
        chk("rsp_route_m1", 64'(m1_rsp_vld), 64'(own));
        chk("s_rsp_rdy", 64'(s_rsp_rdy), 64'(rdy));
        chk("rsp_rdata", 64'(own ? m1_rsp_rdata : m0_rsp_rdata), 64'(s_rsp_rdata));
        chk("rsp_err", 64'(own ? m1_rsp_err : m0_rsp_err), 64'(s_rsp_err));
        if (rdy) void'(rsp_q.pop_front());
      end
    end
    if (s_req_vld && s_req_rdy) begin
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_req.pop_front();
        chk("req_owner_m1", 64'(m1_req_rdy), 64'(e.own));
        chk("req_owner_m0", 64'(m0_req_rdy), 64'(!e.own));
        chk("req_addr", 64'(s_req_addr), 64'(e.addr));
        chk("req_wr", 64'(s_req_wr), 64'(e.wr));
        chk("req_wdata", 64'(s_req_wdata), 64'(e.wdata));
        chk("req_wstrb", 64'(s_req_wstrb), 64'(e.wstrb));
        rsp_q.push_back(e.own);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0; stray_pend = 1'b0;
    rst = 1'b1;
    set_m0(0, '0, 0, '0, '0);
    set_m1(0, '0, 0, '0, '0);
    set_rsp(0, '0, 0);
    m0_rsp_rdy = 0; m1_rsp_rdy = 0; s_req_rdy = 0;

    // reset state: every output low with no inputs active
    #2;
    chk("rst_s_req_vld", 64'(s_req_vld), 64'd0);
    chk("rst_m0_req_rdy", 64'(m0_req_rdy), 64'd0);
    chk("rst_m1_req_rdy", 64'(m1_req_rdy), 64'd0);
    chk("rst_rsp_vld", 64'({m0_rsp_vld, m1_rsp_vld}), 64'd0);
    chk("rst_s_rsp_rdy", 64'(s_rsp_rdy), 64'd0);
    chk("rst_ost_cnt", 64'(ost_cnt), 64'd0);
    chk("rst_err_stray", 64'(err_stray), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();

    // single m0 read, response two cycles later
    s_req_rdy = 1;
    set_m0(1, 32'h1000, 0, '0, '0);
    exp_push(0, 32'h1000, 0, '0, '0);
    step();
    set_m0(0, '0, 0, '0, '0);
    step();
    set_rsp(1, 32'h1234_5678, 0);
    m0_rsp_rdy = 1; m1_rsp_rdy = 1;
    #1 chk("t1_m0_rdata", 64'(m0_rsp_rdata), 64'h1234_5678);
    chk("t1_m1_rsp_vld", 64'(m1_rsp_vld), 64'd0);
    step();
    set_rsp(0, '0, 0);
    step();

    // both masters request continuously for four fires
    set_m0(1, 32'h3000, 0, '0, '0);
    set_m1(1, 32'h4000, 1, 32'hDEAD_BEEF, 4'h3);
    for (int i = 0; i < 4; i++) begin
`ifdef BTI_ARB_RR_EN
      if (i % 2 == 0) exp_push(1, 32'h4000, 1, 32'hDEAD_BEEF, 4'h3);
      else            exp_push(0, 32'h3000, 0, '0, '0);
`else
      exp_push(1, 32'h4000, 1, 32'hDEAD_BEEF, 4'h3);
`endif
    end
    repeat (4) step();
    set_m0(0, '0, 0, '0, '0);
    set_m1(0, '0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      set_rsp(1, 32'hA000_0000 + 32'(i), i[0]);
      step();
    end
    set_rsp(0, '0, 0);
    step();

    // grant lock: m0 write stalls, m1 joins in cycle 2 but must wait
    s_req_rdy = 0;
    set_m0(1, 32'h2000, 1, 32'hA5A5_A5A5, 4'hF);
    exp_push(0, 32'h2000, 1, 32'hA5A5_A5A5, 4'hF);
    exp_push(1, 32'h6000, 0, '0, '0);
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) set_m1(1, 32'h6000, 0, '0, '0);
      if (c == 4) s_req_rdy = 1;
      #1;
      chk("lock_addr", 64'(s_req_addr), 64'h2000);
      chk("lock_wdata", 64'(s_req_wdata), 64'hA5A5_A5A5);
      chk("lock_m1_rdy", 64'(m1_req_rdy), 64'd0);
      step();
    end
    set_m0(0, '0, 0, '0, '0);
    step();
    set_m1(0, '0, 0, '0, '0);
    set_rsp(1, 32'h0000_BEEF, 1);
    repeat (2) step();
    set_rsp(0, '0, 0);
    step();

    // fill to OST_DEPTH, fifth request blocked until a response pops
    set_m0(1, 32'h5000, 0, '0, '0); exp_push(0, 32'h5000, 0, '0, '0); step();
    set_m0(0, '0, 0, '0, '0);
    set_m1(1, 32'h5001, 0, '0, '0); exp_push(1, 32'h5001, 0, '0, '0); step();
    set_m1(1, 32'h5002, 0, '0, '0); exp_push(1, 32'h5002, 0, '0, '0); step();
    set_m1(0, '0, 0, '0, '0);
    set_m0(1, 32'h5003, 0, '0, '0); exp_push(0, 32'h5003, 0, '0, '0); step();
    set_m0(0, '0, 0, '0, '0);
    set_m1(1, 32'h5004, 1, 32'h0BAD_F00D, 4'h1);
    exp_push(1, 32'h5004, 1, 32'h0BAD_F00D, 4'h1);
    #1;
    chk("full_ost", 64'(ost_cnt), 64'd4);
    chk("full_s_req_vld", 64'(s_req_vld), 64'd0);
    chk("full_m1_rdy", 64'(m1_req_rdy), 64'd0);
    step();
    set_rsp(1, 32'h1111_0000, 0);
    #1;
    chk("pop_m0_vld", 64'(m0_rsp_vld), 64'd1);
    chk("pop_s_req_vld", 64'(s_req_vld), 64'd0);
    step();
    set_rsp(0, '0, 0);
    #1 chk("fifth_fire", 64'(s_req_vld && m1_req_rdy), 64'd1);
    step();
    set_m1(0, '0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      set_rsp(1, 32'h2222_0000 + 32'(i), 0);
      step();
    end
    set_rsp(0, '0, 0);
    step();

    // stray response with error flag
    set_rsp(1, 32'h3333_3333, 1);
    step();
    set_rsp(0, '0, 0);
    step();
    step();

    // asynchronous reset with two outstanding requests
    set_m0(1, 32'h7000, 0, '0, '0); exp_push(0, 32'h7000, 0, '0, '0); step();
    set_m0(0, '0, 0, '0, '0);
    set_m1(1, 32'h7001, 0, '0, '0); exp_push(1, 32'h7001, 0, '0, '0); step();
    set_m1(0, '0, 0, '0, '0);
    #2 rst = 1'b1;
    #1 chk("arst_ost_cnt", 64'(ost_cnt), 64'd0);
    #1 rst = 1'b0;
    rsp_q.delete();
    stray_pend = 1'b0;
    @(negedge clk);
    set_rsp(1, 32'h4444_4444, 0);
    step();
    set_rsp(0, '0, 0);
    step();
    step();

    chk("req_left", 64'(exp_req.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
